// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - single-port frame-buffer arbiter between VGA scan-out and game writer
//
// Owns the one port of the 160x120x12 frame-buffer RAM. Display reads take
// absolute priority and are scheduled so that {o_r, o_g, o_b} always hold the
// colour of the 4x4 block containing the current (i_x, i_y). The writer
// receives every cycle that is not a display slot.
//
// Optional build macro: FB_WR_BLANK_ONLY_EN - when defined, writes are accepted
// only during blanking, outside the end-of-line slot, so the display never tears.
//
// Ports:
//   clk_vga, rst_vga          pixel clock, asynchronous active-high reset
//   i_x, i_y, i_de            current pixel coordinate and visible-area flag
//   i_wr_req, i_wr_addr,      writer request, held with address and data
//   i_wr_data                 until o_wr_ack
//   o_wr_ack                  combinational write accept for this edge
//   o_ram_en, o_ram_we,       registered RAM command
//   o_ram_addr, o_ram_wdata
//   i_ram_rdata               synchronous RAM read data (one cycle latency)
//   o_r, o_g, o_b             registered display colour
`timescale 1ns/1ps

module vga_fb_arbiter #(
    parameter int FB_W   = 160,
    parameter int FB_H   = 120,
    parameter int ADDR_W = 15
) (
    input  logic              clk_vga,
    input  logic              rst_vga,
    input  logic [10:0]       i_x,
    input  logic [10:0]       i_y,
    input  logic              i_de,
    input  logic              i_wr_req,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [11:0]       i_wr_data,
    output logic              o_wr_ack,
    output logic              o_ram_en,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [11:0]       o_ram_wdata,
    input  logic [11:0]       i_ram_rdata,
    output logic [3:0]        o_r,
    output logic [3:0]        o_g,
    output logic [3:0]        o_b
);

    function automatic logic [ADDR_W-1:0] fb_addr(input logic [6:0] r, input logic [7:0] c);
        // row * 160 without a multiplier
        return (ADDR_W'(r) << 7) + (ADDR_W'(r) << 5) + ADDR_W'(c);
    endfunction

    logic [7:0]        col;
    logic [6:0]        row;
    logic [6:0]        next_row;
    logic              de_d;
    logic              col_slot;
    logic              eol_slot;
    logic              display_slot;
    logic              wr_window;
    logic              wr_in_range;
    logic [ADDR_W-1:0] rd_addr;

    logic              rd_v1, rd_v2;
    logic              rd_eol1, rd_eol2;
    logic              eol_load;
    logic [11:0]       prefetch;

    logic              unused_bits;

    assign col = i_x[9:2];
    assign row = i_y[8:2];
    assign unused_bits = ^{i_x[10], i_y[10:9]};

    // Column 0 of the line that follows: only the last line of a block row
    // moves on to the next row, wrapping to row 0 after the bottom row.
    always_comb begin
        next_row = row;
        if (i_y[1:0] == 2'd3) begin
            next_row = (row == 7'(FB_H - 1)) ? 7'd0 : row + 7'd1;
        end
    end

    // Phase 0 of block c fetches block c+1; the last block has no successor.
    assign col_slot     = i_de && (i_x[1:0] == 2'd0) && (col != 8'(FB_W - 1));
    assign eol_slot     = de_d && !i_de;
    assign display_slot = col_slot || eol_slot;
    assign rd_addr      = col_slot ? fb_addr(row, col + 8'd1) : fb_addr(next_row, 8'd0);

`ifdef FB_WR_BLANK_ONLY_EN
    assign wr_window = !i_de && !de_d;
`else
    assign wr_window = 1'b1;
`endif

    assign o_wr_ack    = i_wr_req && !display_slot && wr_window;
    assign wr_in_range = i_wr_addr < ADDR_W'(FB_W * FB_H);

    always_ff @(posedge clk_vga or posedge rst_vga) begin
        if (rst_vga) begin
            de_d        <= 1'b0;
            o_ram_en    <= 1'b0;
            o_ram_we    <= 1'b0;
            o_ram_addr  <= '0;
            o_ram_wdata <= '0;
            rd_v1       <= 1'b0;
            rd_v2       <= 1'b0;
            rd_eol1     <= 1'b0;
            rd_eol2     <= 1'b0;
            eol_load    <= 1'b0;
            prefetch    <= '0;
            o_r         <= '0;
            o_g         <= '0;
            o_b         <= '0;
        end else begin
            de_d <= i_de;

            if (display_slot) begin
                o_ram_en   <= 1'b1;
                o_ram_we   <= 1'b0;
                o_ram_addr <= rd_addr;
            end else if (o_wr_ack && wr_in_range) begin
                o_ram_en    <= 1'b1;
                o_ram_we    <= 1'b1;
                o_ram_addr  <= i_wr_addr;
                o_ram_wdata <= i_wr_data;
            end else begin
                // Out-of-range writes are acked and dropped here.
                o_ram_en <= 1'b0;
                o_ram_we <= 1'b0;
            end

            // v1: RAM is being accessed; v2: read data is on i_ram_rdata.
            rd_v1   <= display_slot;
            rd_eol1 <= eol_slot;
            rd_v2   <= rd_v1;
            rd_eol2 <= rd_eol1;
            if (rd_v2) begin
                prefetch <= i_ram_rdata;
            end
            eol_load <= rd_v2 && rd_eol2;

            // Phase 3 hands block c+1 to the output for the next four pixels;
            // the end-of-line fetch is shown through blanking until column 0.
            if ((i_de && (i_x[1:0] == 2'd3)) || eol_load) begin
                {o_r, o_g, o_b} <= prefetch;
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - self-checking bench for vga_fb_arbiter
`timescale 1ns/1ps

module tb_vga_fb_arbiter;

    localparam int FB_W   = 160;
    localparam int FB_H   = 120;
    localparam int ADDR_W = 15;
    localparam int NPIX   = FB_W * FB_H;
    localparam int VIS    = 640;
    localparam int HBL    = 160;
    localparam int NVEC   = 14;

    logic              clk_vga     = 1'b0;
    logic              rst_vga     = 1'b1;
    logic [10:0]       i_x         = '0;
    logic [10:0]       i_y         = '0;
    logic              i_de        = 1'b0;
    logic              i_wr_req    = 1'b0;
    logic [ADDR_W-1:0] i_wr_addr   = '0;
    logic [11:0]       i_wr_data   = '0;
    logic              o_wr_ack;
    logic              o_ram_en;
    logic              o_ram_we;
    logic [ADDR_W-1:0] o_ram_addr;
    logic [11:0]       o_ram_wdata;
    logic [11:0]       i_ram_rdata = '0;
    logic [3:0]        o_r, o_g, o_b;

    always #5 clk_vga = ~clk_vga;

    vga_fb_arbiter #(.FB_W(FB_W), .FB_H(FB_H), .ADDR_W(ADDR_W)) dut (
        .clk_vga     (clk_vga),
        .rst_vga     (rst_vga),
        .i_x         (i_x),
        .i_y         (i_y),
        .i_de        (i_de),
        .i_wr_req    (i_wr_req),
        .i_wr_addr   (i_wr_addr),
        .i_wr_data   (i_wr_data),
        .o_wr_ack    (o_wr_ack),
        .o_ram_en    (o_ram_en),
        .o_ram_we    (o_ram_we),
        .o_ram_addr  (o_ram_addr),
        .o_ram_wdata (o_ram_wdata),
        .i_ram_rdata (i_ram_rdata),
        .o_r         (o_r),
        .o_g         (o_g),
        .o_b         (o_b)
    );

    logic [11:0] ram     [NPIX];
    logic [11:0] ref_mem [NPIX];
    int          ram_wr_cnt = 0;
    logic        preload    = 1'b0;
    int unsigned seed       = 0;

    int errors = 0;
    int checks = 0;

    logic              prev_de = 1'b0;
    logic              rw_pend = 1'b0;
    logic [ADDR_W-1:0] rw_addr = '0;
    logic [11:0]       rw_data = '0;
    int                ack_cnt = 0;

    typedef struct {
        logic              de;
        int                x;
        int                y;
        logic              req;
        logic [ADDR_W-1:0] wa;
        logic              exp_ack;
        logic              exp_en;
        logic              exp_we;
        logic [ADDR_W-1:0] exp_addr;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic logic [11:0] pat(input int i);
        int unsigned h;
        h = unsigned'(i) * 32'h9E3779B1 + seed;
        return h[19:8];
    endfunction

    // Synchronous single-port frame-buffer RAM.
    always @(posedge clk_vga) begin
        if (preload) begin
            for (int i = 0; i < NPIX; i++) ram[i] <= pat(i);
        end else if (o_ram_en) begin
            if (o_ram_we) begin
                if (int'(o_ram_addr) < NPIX) ram[o_ram_addr] <= o_ram_wdata;
                ram_wr_cnt <= ram_wr_cnt + 1;
            end else begin
                i_ram_rdata <= (int'(o_ram_addr) < NPIX) ? ram[o_ram_addr] : 12'h000;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Display slots: phase 0 of blocks 0..158, and the first blanking cycle.
    function automatic logic model_ack(input logic req, input logic de, input int x, input logic pde);
        logic slot;
        slot = (de && (x % 4 == 0) && (x / 4 != FB_W - 1)) || (pde && !de);
`ifdef FB_WR_BLANK_ONLY_EN
        return req && !slot && !de && !pde;
`else
        return req && !slot;
`endif
    endfunction

    function automatic logic [11:0] exp_pix(input int x, input int y);
        return ref_mem[(y / 4) * FB_W + x / 4];
    endfunction

    // mode 0: no writer, 1: hold 0xABC -> 0x0123 during visible, 2: random writer
    task automatic run_line(input int y, input int mode, input logic black_col0);
        logic              de, req, ea;
        int                x;
        logic [ADDR_W-1:0] wa;
        logic [11:0]       wd;
        for (int t = 0; t < VIS + HBL; t++) begin
            de  = (t < VIS);
            x   = de ? t : VIS - 1;
            req = 1'b0;
            wa  = '0;
            wd  = '0;
            if (mode == 1) begin
                req = de;
                wa  = 15'h0123;
                wd  = 12'hABC;
            end else if (mode == 2) begin
                if (!rw_pend && t < VIS + HBL - 20 && $urandom_range(1) == 1) begin
                    rw_pend = 1'b1;
                    if ($urandom_range(7) == 0) rw_addr = ADDR_W'($urandom_range(32767, NPIX));
                    else                        rw_addr = ADDR_W'($urandom_range(NPIX - 1, 3 * FB_W));
                    rw_data = 12'($urandom);
                end
                req = rw_pend;
                wa  = rw_addr;
                wd  = rw_data;
            end
            i_de = de; i_x = 11'(x); i_y = 11'(y);
            i_wr_req = req; i_wr_addr = wa; i_wr_data = wd;
            ea = model_ack(req, de, x, prev_de);
            @(negedge clk_vga);
            check($sformatf("ack y=%0d t=%0d", y, t), 32'(o_wr_ack), 32'(ea));
            if (de) begin
                check($sformatf("pixel y=%0d x=%0d", y, x), 32'({o_r, o_g, o_b}),
                      32'((black_col0 && x < 4) ? 12'h000 : exp_pix(x, y)));
            end
            if (ea) begin
                ack_cnt++;
                if (mode == 2) rw_pend = 1'b0;
                if (int'(wa) < NPIX) ref_mem[wa] = wd;
            end
            @(posedge clk_vga); #1;
            prev_de = de;
        end
    endtask

    task automatic idle(input int n);
        i_de = 1'b0; i_wr_req = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk_vga); #1;
            prev_de = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_acks;
        int c0;
        int bad;

        //            de  x    y   req wa     ack en we addr
        vecs[0]  = '{1'b1,   0,   0, 1'b1, 15'd5,     1'b0, 1'b1, 1'b0, 15'd1};
        vecs[1]  = '{1'b1,   1,   0, 1'b1, 15'd5,     1'b1, 1'b1, 1'b1, 15'd5};
        vecs[2]  = '{1'b1, 636,   0, 1'b1, 15'd7,     1'b1, 1'b1, 1'b1, 15'd7};
        vecs[3]  = '{1'b1, 632,   8, 1'b0, 15'd0,     1'b0, 1'b1, 1'b0, 15'd479};
        vecs[4]  = '{1'b0, 639,  11, 1'b1, 15'd9,     1'b0, 1'b1, 1'b0, 15'd480};
        vecs[5]  = '{1'b0, 639,  11, 1'b1, 15'd19200, 1'b1, 1'b0, 1'b0, 15'd480};
        vecs[6]  = '{1'b0, 639,  11, 1'b1, 15'd19199, 1'b1, 1'b1, 1'b1, 15'd19199};
        vecs[7]  = '{1'b1,   4, 479, 1'b0, 15'd0,     1'b0, 1'b1, 1'b0, 15'd19042};
        vecs[8]  = '{1'b0, 639, 479, 1'b0, 15'd0,     1'b0, 1'b1, 1'b0, 15'd0};
        vecs[9]  = '{1'b0, 639, 479, 1'b0, 15'd0,     1'b0, 1'b0, 1'b0, 15'd0};
        vecs[10] = '{1'b1,   9,   1, 1'b1, 15'd100,   1'b1, 1'b1, 1'b1, 15'd100};
        vecs[11] = '{1'b1,   8,   2, 1'b0, 15'd0,     1'b0, 1'b1, 1'b0, 15'd3};
        vecs[12] = '{1'b0, 639,   2, 1'b1, 15'd33,    1'b0, 1'b1, 1'b0, 15'd0};
        vecs[13] = '{1'b0, 639,   2, 1'b1, 15'd33,    1'b1, 1'b1, 1'b1, 15'd33};

        // Reset state
        repeat (3) @(posedge clk_vga);
        #1;
        check("reset en",    32'(o_ram_en),          32'd0);
        check("reset we",    32'(o_ram_we),          32'd0);
        check("reset addr",  32'(o_ram_addr),        32'd0);
        check("reset wdata", 32'(o_ram_wdata),       32'd0);
        check("reset rgb",   32'({o_r, o_g, o_b}),  32'd0);
        check("reset ack",   32'(o_wr_ack),          32'd0);
        rst_vga = 1'b0;
        prev_de = 1'b0;
        idle(2);

`ifndef FB_WR_BLANK_ONLY_EN
        for (int k = 0; k < NVEC; k++) begin
            i_de = vecs[k].de; i_x = 11'(vecs[k].x); i_y = 11'(vecs[k].y);
            i_wr_req = vecs[k].req; i_wr_addr = vecs[k].wa;
            i_wr_data = vecs[k].wa[11:0] ^ 12'h5A5;
            @(negedge clk_vga);
            check($sformatf("vec%0d ack", k), 32'(o_wr_ack), 32'(vecs[k].exp_ack));
            @(posedge clk_vga); #1;
            check($sformatf("vec%0d en", k),   32'(o_ram_en),   32'(vecs[k].exp_en));
            check($sformatf("vec%0d we", k),   32'(o_ram_we),   32'(vecs[k].exp_we));
            check($sformatf("vec%0d addr", k), 32'(o_ram_addr), 32'(vecs[k].exp_addr));
            if (vecs[k].exp_we)
                check($sformatf("vec%0d wdata", k), 32'(o_ram_wdata), 32'(vecs[k].wa[11:0] ^ 12'h5A5));
            prev_de = vecs[k].de;
        end
`endif

        // Random frame-buffer contents, then a clean pipeline.
        seed = $urandom;
        idle(1);
        preload = 1'b1;
        @(posedge clk_vga); #1;
        preload = 1'b0;
        for (int i = 0; i < NPIX; i++) ref_mem[i] = pat(i);
        rst_vga = 1'b1;
        #2;
        rst_vga = 1'b0;
        prev_de = 1'b0;
        idle(20);

        // Bottom rows, wrap to row 0, first line shows black in column 0.
        run_line(476, 0, 1'b1);
        run_line(477, 0, 1'b0);
        run_line(478, 0, 1'b0);
        run_line(479, 0, 1'b0);
        run_line(0,   0, 1'b0);

        // Priority: write held across a visible line.
        ack_cnt = 0;
        c0 = ram_wr_cnt;
`ifdef FB_WR_BLANK_ONLY_EN
        exp_acks = 0;
`else
        exp_acks = VIS - (FB_W - 1);
`endif
        run_line(1, 1, 1'b0);
        check("priority ack count", 32'(ack_cnt), 32'(exp_acks));
        check("priority ram writes", 32'(ram_wr_cnt - c0), 32'(ack_cnt));

        // Random writer interleaved with scan-out.
        run_line(2, 2, 1'b0);
        for (int yy = 3; yy < 8; yy++) run_line(yy, 0, 1'b0);

        bad = 0;
        for (int i = 0; i < NPIX; i++) if (ram[i] !== ref_mem[i]) bad++;
        check("ram contents mismatching words", 32'(bad), 32'd0);

        // Asynchronous reset mid-line with a write in flight.
        i_de = 1'b1; i_x = 11'd301; i_y = 11'd16;
        i_wr_req = 1'b1; i_wr_addr = 15'd600; i_wr_data = 12'h5C3;
        @(posedge clk_vga); #1;
`ifndef FB_WR_BLANK_ONLY_EN
        check("pre-reset write en", 32'({o_ram_en, o_ram_we}), 32'd3);
`endif
        #2;
        rst_vga = 1'b1;
        #1;
        check("async reset en",    32'(o_ram_en),         32'd0);
        check("async reset we",    32'(o_ram_we),         32'd0);
        check("async reset addr",  32'(o_ram_addr),       32'd0);
        check("async reset wdata", 32'(o_ram_wdata),      32'd0);
        check("async reset rgb",   32'({o_r, o_g, o_b}), 32'd0);
        check("async reset ack",   32'(o_wr_ack),         32'(model_ack(1'b1, 1'b1, 301, 1'b0)));
        @(negedge clk_vga);
        rst_vga  = 1'b0;
        i_de     = 1'b0;
        i_wr_req = 1'b0;
        prev_de  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk_vga); #1;
            check($sformatf("post-reset idle %0d", k), 32'(o_ram_en), 32'd0);
        end
        i_de = 1'b1; i_x = 11'd0; i_y = 11'd0;
        @(posedge clk_vga); #1;
        check("first slot after reset", 32'({o_ram_en, o_ram_we, o_ram_addr}),
              32'({1'b1, 1'b0, 15'd1}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
